muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide execution unit. Consumes rs1/rs2 operands read from the
//  register file. Produces a result for the register-file write port (rd addr/data/wren)
//  through a valid/ready handshake. Stalls the core while busy; one operation in flight.
// PARAMETERS
//  XLEN        32   operand/result width; iteration counter is $clog2(XLEN) bits
// PORTS
//  i_clk        in   1     clock
//  i_rst_n      in   1     reset, asynchronous, active-low
//  i_flush      in   1     synchronous abort of any in-flight op
//  i_valid      in   1     request valid
//  o_ready      out  1     unit can accept a request (high only in IDLE)
//  i_funct3     in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  i_rs1_data   in   XLEN  operand A (dividend / multiplicand)
//  i_rs2_data   in   XLEN  operand B (divisor / multiplier)
//  i_rd_addr    in   5     destination register
//  o_valid      out  1     result valid (high only in DONE)
//  i_wb_ready   in   1     writeback accepts result
//  o_rd_addr    out  5     destination register of result
//  o_rd_data    out  XLEN  result
//  o_rd_wren    out  1     o_valid & i_wb_ready & (|o_rd_addr)
//  o_busy       out  1     state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE. All registers 0. o_valid=0, o_ready=1, o_busy=0, o_rd_data=0, o_rd_addr=0.
//  - Accept on i_valid & o_ready. Operands, funct3 and rd are latched at accept; inputs are then don't-care.
//  - FSM: IDLE -> CALC (counter=XLEN-1) -> FIXUP -> DONE -> IDLE.
//    CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle; leaves CALC when counter==0.
//    FIXUP: applies result sign correction and selects hi/lo word or quotient/remainder.
//    DONE: o_valid=1 and outputs stable; on i_wb_ready goes to IDLE. No new accept in the same cycle.
//  - Latency: accept in cycle 0; CALC in cycles 1..32; FIXUP in cycle 33; o_valid first high in cycle 34.
//  - Signedness: MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU unsigned.
//    The core runs on magnitudes. The 2XLEN-bit product is negated in FIXUP when the signs differ.
//  - DIV/REM: quotient sign = sign(a)^sign(b); remainder sign = sign(a).
//  - Fast paths, decided at accept. Go IDLE -> DONE, so o_valid is high in cycle 1:
//    divisor==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
//    DIV with a=0x80000000, b=0xFFFFFFFF: quotient 0x80000000; REM -> 0.
//  - rd==0: the op executes and o_valid asserts, but o_rd_wren stays 0.
//  - i_flush, in any state: next state IDLE, o_valid=0, result discarded. Flush beats accept in the same cycle.
//  - Async reset mid-op: immediate IDLE; no write is ever issued for the aborted op.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined:
//    MUL* ops compute the full 2XLEN product in one cycle. Path is IDLE -> FIXUP -> DONE, o_valid in cycle 2.
//    Divide is unchanged.
//  Not defined: all multiplies are iterative, 34-cycle latency.
// STRUCTURE
//  muldiv_pkg:
//    typedef enum logic[2:0] for funct3 ops (OP_MUL..OP_REMU).
//    typedef enum for FSM state (ST_IDLE, ST_CALC, ST_FIXUP, ST_DONE).
//    localparams for divide-by-zero / overflow constants.
//  One sub-module, muldiv_datapath: shift registers, adder/subtractor and sign fixup.
//  muldiv_unit holds the FSM, counter, handshake and fast-path detection.
// TESTING
//  1. MUL 7 x -3 (0xFFFFFFFD), rd=5 -> o_valid at cycle 34. o_rd_data=0xFFFFFFEB, o_rd_wren=1 on i_wb_ready.
//  2. MULH/MULHSU/MULHU with 0x80000000 x 0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4. DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both at cycle 1.
//     DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1.
//  5. i_flush at cycle 10 of a DIV -> o_busy=0 and o_ready=1 next cycle, never o_valid.
//     A new MUL accepted right after completes correctly.
//  6. Hold i_wb_ready=0 for 5 cycles in DONE -> outputs stable, o_ready=0. rd=0 -> o_rd_wren stays 0.
//     Async reset mid-CALC -> all outputs at reset values.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared types and constants for the RV32M multiply/divide unit.
//   - op_e    : funct3 encoding of the M-extension operations
//   - state_e : control FSM states
//   - fast-path result constants (divide by zero, signed overflow)
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Quotient returned for any divide by zero
    localparam logic [31:0] DIV0_QUOT    = 32'hFFFF_FFFF;
    // Signed overflow case: most negative value divided by -1
    localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_QUOT     = 32'h8000_0000;
    localparam logic [31:0] OVF_REM      = 32'h0000_0000;

endpackage

// File: rtl/muldiv_datapath.sv
// -----------------------------------------------------------------------------
// muldiv_datapath
//   Operand magnitude conversion, iterative shift-add multiplier / restoring
//   divider sharing one {hi,lo} register pair, and final sign fixup.
//   Optional single-cycle multiply when MULDIV_FAST_MUL_EN is defined.
// Ports
//   i_clk, i_rst_n   clock, async active-low reset
//   i_load           latch operands/op (accept cycle)
//   i_step           one multiply or divide iteration
//   i_fixup          compute and register the signed final result
//   i_fast           register i_fast_data as the result (fast paths)
//   i_fast_data      precomputed fast-path result
//   i_op             funct3 of the request
//   i_rs1_data       operand A
//   i_rs2_data       operand B
//   o_result         registered result
// -----------------------------------------------------------------------------
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_fixup,
    input  logic            i_fast,
    input  logic [XLEN-1:0] i_fast_data,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output logic [XLEN-1:0] o_result
);

    op_e             op_r;
    logic            neg_a_r;
    logic            neg_b_r;
    logic [XLEN-1:0] hi_r;
    logic [XLEN-1:0] lo_r;
    logic [XLEN-1:0] opb_r;
    logic [XLEN-1:0] res_r;

    logic            neg_a_s;
    logic            neg_b_s;
    logic [XLEN-1:0] mag_a_s;
    logic [XLEN-1:0] mag_b_s;
    logic [XLEN-1:0] hi_next_s;
    logic [XLEN-1:0] lo_next_s;
    logic [XLEN:0]   sum_s;
    logic [XLEN:0]   rem_shift_s;
    logic            ge_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0] quo_fix_s;
    logic [XLEN-1:0] rem_fix_s;
    logic [XLEN-1:0] fix_s;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod_s;
`endif

    // Operand sign decode and magnitude conversion at accept
    always_comb begin
        neg_a_s = 1'b0;
        neg_b_s = 1'b0;
        case (op_e'(i_op))
            OP_MULH, OP_DIV, OP_REM: begin
                neg_a_s = i_rs1_data[XLEN-1];
                neg_b_s = i_rs2_data[XLEN-1];
            end
            OP_MULHSU: begin
                neg_a_s = i_rs1_data[XLEN-1];
                neg_b_s = 1'b0;
            end
            default: begin
                neg_a_s = 1'b0;
                neg_b_s = 1'b0;
            end
        endcase
        mag_a_s = neg_a_s ? ({XLEN{1'b0}} - i_rs1_data) : i_rs1_data;
        mag_b_s = neg_b_s ? ({XLEN{1'b0}} - i_rs2_data) : i_rs2_data;
    end

`ifdef MULDIV_FAST_MUL_EN
    // Full-width product of the magnitudes for the single-cycle multiply
    always_comb begin
        fast_prod_s = {{XLEN{1'b0}}, mag_a_s} * {{XLEN{1'b0}}, mag_b_s};
    end
`endif

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        sum_s       = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
        rem_shift_s = {hi_r, lo_r[XLEN-1]};
        ge_s        = (rem_shift_s >= {1'b0, opb_r});
        if (op_r[2]) begin
            // Partial remainder is kept below the divisor, so XLEN bits suffice
            hi_next_s = ge_s ? XLEN'(rem_shift_s - {1'b0, opb_r}) : rem_shift_s[XLEN-1:0];
            lo_next_s = {lo_r[XLEN-2:0], ge_s};
        end else begin
            hi_next_s = sum_s[XLEN:1];
            lo_next_s = {sum_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Sign correction and word selection
    always_comb begin
        prod_fix_s = (neg_a_r ^ neg_b_r) ? ({(2*XLEN){1'b0}} - {hi_r, lo_r}) : {hi_r, lo_r};
        quo_fix_s  = (neg_a_r ^ neg_b_r) ? ({XLEN{1'b0}} - lo_r) : lo_r;
        rem_fix_s  = neg_a_r ? ({XLEN{1'b0}} - hi_r) : hi_r;
        case (op_r)
            OP_MUL:                       fix_s = prod_fix_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_s = prod_fix_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_s = quo_fix_s;
            OP_REM, OP_REMU:              fix_s = rem_fix_s;
            default:                      fix_s = {XLEN{1'b0}};
        endcase
    end

    // Operand, iteration and result registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_r    <= OP_MUL;
            neg_a_r <= 1'b0;
            neg_b_r <= 1'b0;
            hi_r    <= {XLEN{1'b0}};
            lo_r    <= {XLEN{1'b0}};
            opb_r   <= {XLEN{1'b0}};
            res_r   <= {XLEN{1'b0}};
        end else begin
            if (i_load) begin
                op_r    <= op_e'(i_op);
                neg_a_r <= neg_a_s;
                neg_b_r <= neg_b_s;
                opb_r   <= mag_b_s;
`ifdef MULDIV_FAST_MUL_EN
                if (!i_op[2]) begin
                    {hi_r, lo_r} <= fast_prod_s;
                end else begin
                    hi_r <= {XLEN{1'b0}};
                    lo_r <= mag_a_s;
                end
`else
                hi_r <= {XLEN{1'b0}};
                lo_r <= mag_a_s;
`endif
            end else if (i_step) begin
                hi_r <= hi_next_s;
                lo_r <= lo_next_s;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end

            if (i_fast) begin
                res_r <= i_fast_data;
            end else if (i_fixup) begin
                res_r <= fix_s;
            end else begin
                res_r <= res_r;
            end
        end
    end

    assign o_result = res_r;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit: control FSM, iteration counter,
//   valid/ready handshake, rd tracking and fast-path detection.
//   Build option: MULDIV_FAST_MUL_EN -> multiplies complete in one cycle
//   (IDLE -> FIXUP -> DONE); divide is unaffected.
// Ports
//   i_clk, i_rst_n      clock, async active-low reset
//   i_flush             synchronous abort of any in-flight operation
//   i_valid / o_ready   request handshake (o_ready only in IDLE)
//   i_funct3            operation select
//   i_rs1_data          operand A (dividend / multiplicand)
//   i_rs2_data          operand B (divisor / multiplier)
//   i_rd_addr           destination register
//   o_valid/i_wb_ready  result handshake (o_valid only in DONE)
//   o_rd_addr/o_rd_data result destination and value
//   o_rd_wren           register-file write enable (suppressed for rd=0)
//   o_busy              unit not idle
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [4:0]      i_rd_addr,
    output logic            o_valid,
    input  logic            i_wb_ready,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_rd_wren,
    output logic            o_busy
);

    localparam int CW = $clog2(XLEN);

    state_e          state_r;
    state_e          state_n_s;
    logic [CW-1:0]   cnt_r;
    logic [4:0]      rd_r;

    logic            accept_s;
    logic            div0_s;
    logic            ovf_s;
    logic            fast_s;
    logic            fast_mul_s;
    logic [XLEN-1:0] fast_data_s;

    // Fast-path detection on the incoming request
    always_comb begin
        div0_s = i_funct3[2] && (i_rs2_data == {XLEN{1'b0}});
        ovf_s  = ((i_funct3 == OP_DIV) || (i_funct3 == OP_REM)) &&
                 (i_rs1_data == OVF_DIVIDEND) && (i_rs2_data == OVF_DIVISOR);
        fast_s = div0_s || ovf_s;
        // funct3[1] distinguishes REM/REMU from DIV/DIVU
        if (div0_s) begin
            fast_data_s = i_funct3[1] ? i_rs1_data : DIV0_QUOT;
        end else begin
            fast_data_s = i_funct3[1] ? OVF_REM : OVF_QUOT;
        end
`ifdef MULDIV_FAST_MUL_EN
        fast_mul_s = ~i_funct3[2];
`else
        fast_mul_s = 1'b0;
`endif
    end

    assign accept_s = i_valid && (state_r == ST_IDLE) && !i_flush;

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (fast_s) begin
                        state_n_s = ST_DONE;
                    end else if (fast_mul_s) begin
                        state_n_s = ST_FIXUP;
                    end else begin
                        state_n_s = ST_CALC;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_n_s = ST_FIXUP;
                end else begin
                    state_n_s = ST_CALC;
                end
            end
            ST_FIXUP: state_n_s = ST_DONE;
            ST_DONE: begin
                if (i_wb_ready) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_DONE;
                end
            end
            default: state_n_s = ST_IDLE;
        endcase
        if (i_flush) begin
            state_n_s = ST_IDLE;
        end else begin
            state_n_s = state_n_s;
        end
    end

    // State, iteration counter and destination register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            rd_r    <= 5'd0;
        end else begin
            state_r <= state_n_s;
            if (accept_s) begin
                cnt_r <= CW'(XLEN - 1);
                rd_r  <= i_rd_addr;
            end else if (state_r == ST_CALC) begin
                cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (accept_s),
        .i_step      (state_r == ST_CALC),
        .i_fixup     ((state_r == ST_FIXUP) && !i_flush),
        .i_fast      (accept_s && fast_s),
        .i_fast_data (fast_data_s),
        .i_op        (i_funct3),
        .i_rs1_data  (i_rs1_data),
        .i_rs2_data  (i_rs2_data),
        .o_result    (o_rd_data)
    );

    assign o_ready   = (state_r == ST_IDLE);
    assign o_valid   = (state_r == ST_DONE);
    assign o_busy    = (state_r != ST_IDLE);
    assign o_rd_addr = rd_r;
    assign o_rd_wren = o_valid && i_wb_ready && (rd_r != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed self-checking bench for muldiv_unit. Inputs change 1 time unit
//   after the rising edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        ovalid;
    logic        wb_ready = 1'b0;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_wren;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int mul_lat;

    muldiv_unit dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_flush    (flush),
        .i_valid    (valid),
        .o_ready    (ready),
        .i_funct3   (funct3),
        .i_rs1_data (rs1),
        .i_rs2_data (rs2),
        .i_rd_addr  (rd),
        .o_valid    (ovalid),
        .i_wb_ready (wb_ready),
        .o_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_rd_wren  (rd_wren),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle, then scramble the inputs
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d);
        valid  = 1'b1;
        funct3 = f;
        rs1    = a;
        rs2    = b;
        rd     = d;
        tick();
        valid  = 1'b0;
        funct3 = 3'($urandom);
        rs1    = $urandom;
        rs2    = $urandom;
        rd     = 5'($urandom);
    endtask

    // Full operation: latency, result, optional DONE hold, writeback
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d,
                          input logic [31:0] exp, input int exp_lat, input int hold);
        int lat;
        issue(f, a, b, d);
        lat = 1;
        while (!ovalid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_data"}, {32'd0, rd_data}, {32'd0, exp});
        check({tag, "_rd"}, {59'd0, rd_addr}, {59'd0, d});
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, {63'd0, ovalid}, 64'd1);
            check({tag, "_hold_data"}, {32'd0, rd_data}, {32'd0, exp});
            check({tag, "_hold_ready"}, {63'd0, ready}, 64'd0);
            check({tag, "_hold_wren"}, {63'd0, rd_wren}, 64'd0);
        end
        wb_ready = 1'b1;
        #1;
        check({tag, "_wren"}, {63'd0, rd_wren}, {63'd0, (d != 5'd0)});
        tick();
        wb_ready = 1'b0;
        check({tag, "_idle_valid"}, {63'd0, ovalid}, 64'd0);
        check({tag, "_idle_ready"}, {63'd0, ready}, 64'd1);
    endtask

    initial begin
        int seen;
`ifdef MULDIV_FAST_MUL_EN
        mul_lat = 2;
`else
        mul_lat = 34;
`endif
        // Reset state
        #2;
        check("rst_valid", {63'd0, ovalid}, 64'd0);
        check("rst_ready", {63'd0, ready}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_data", {32'd0, rd_data}, 64'd0);
        check("rst_rd", {59'd0, rd_addr}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Multiplies
        run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, mul_lat, 0);
        run_op("mulh", 3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, mul_lat, 0);
        run_op("mulhsu", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h8000_0000, mul_lat, 0);
        run_op("mulhu", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h7FFF_FFFF, mul_lat, 0);

        // Divides
        run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 34, 0);
        run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 34, 0);
        run_op("divu", 3'b101, 32'd100, 32'd7, 5'd8, 32'd14, 34, 0);
        run_op("remu", 3'b111, 32'd100, 32'd7, 5'd9, 32'd2, 34, 0);

        // Fast paths
        run_op("divu0", 3'b101, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 1, 0);
        run_op("rem0", 3'b110, 32'd5, 32'd0, 5'd11, 32'd5, 1, 0);
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1, 0);
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1, 0);

        // Flush at cycle 10 of a divide, then a multiply right after
        issue(3'b100, 32'd1000, 32'd3, 5'd4);
        repeat (9) tick();
        check("flush_busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_ready", {63'd0, ready}, 64'd1);
        check("flush_valid", {63'd0, ovalid}, 64'd0);
        run_op("mul_after_flush", 3'b000, 32'h1234_5678, 32'h0000_0010, 5'd3, 32'h2345_6780,
               mul_lat, 0);

        // Flush beats accept in the same cycle
        valid  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'b101;
        rs1    = 32'd9;
        rs2    = 32'd0;
        rd     = 5'd1;
        tick();
        valid = 1'b0;
        flush = 1'b0;
        check("flush_vs_accept_busy", {63'd0, busy}, 64'd0);
        check("flush_vs_accept_valid", {63'd0, ovalid}, 64'd0);

        // Held writeback with rd=0
        run_op("remu_rd0_hold", 3'b111, 32'd100, 32'd7, 5'd0, 32'd2, 34, 5);

        // Async reset in the middle of CALC
        issue(3'b000, 32'd3, 32'd5, 5'd7);
        repeat (5) tick();
        check("arst_busy_before", {63'd0, busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {63'd0, ovalid}, 64'd0);
        check("arst_ready", {63'd0, ready}, 64'd1);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_data", {32'd0, rd_data}, 64'd0);
        check("arst_rd", {59'd0, rd_addr}, 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        wb_ready = 1'b1;
        seen     = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ovalid || rd_wren) seen++;
        end
        wb_ready = 1'b0;
        check("arst_no_write", 64'(seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
